// File: rtl/dly_timer_pkg.sv
// Shared definitions for the multi-channel delay timer bank: channel modes
// and a width helper for the prescaler.
package dly_timer_pkg;

    localparam logic [1:0] MODE_PERIODIC = 2'b00;
    localparam logic [1:0] MODE_LATCH    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dly_timer_ch.sv
// One delay-timer channel: tick-driven up-counter with live compare,
// periodic / latch / one-shot expiry handling and a registered rise pulse.
module dly_timer_ch
    import dly_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             iRst_n,
    input  logic             tick,
    input  logic             clear_n,
    input  logic             en,
    input  logic [CNT_W-1:0] dly_time,
    input  logic [1:0]       mode,
    output logic             timeout,
    output logic             rise
);

    logic [CNT_W-1:0] cnt_reg;
    logic             fired_reg;
    logic             timeout_q_reg;
    logic             latch_mode;
    logic             expire;

    // Reserved mode 2'b11 behaves like LATCH.
    assign latch_mode = (mode == MODE_LATCH) || (mode == 2'b11);
    assign expire     = tick && (cnt_reg >= dly_time);

    always_ff @(posedge clk_in or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_reg       <= '0;
            fired_reg     <= 1'b0;
            timeout       <= 1'b0;
            timeout_q_reg <= 1'b0;
            rise          <= 1'b0;
        end else begin
            timeout_q_reg <= timeout;
            rise          <= timeout & ~timeout_q_reg;
            if (!clear_n || !en) begin
                cnt_reg   <= '0;
                fired_reg <= 1'b0;
                timeout   <= 1'b0;
            end else if (fired_reg && (mode != MODE_PERIODIC)) begin
                // Spent channel freezes: LATCH keeps the output even if the
                // delay is raised later, ONESHOT stays quiet.
                timeout <= latch_mode;
            end else if (expire) begin
                timeout <= 1'b1;
                if (mode == MODE_PERIODIC) begin
                    cnt_reg <= '0;
                end else begin
                    fired_reg <= 1'b1;
                end
            end else begin
                timeout <= 1'b0;
                if (tick) cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dly_timer_bank.sv
// Bank of CH_NUM independent delay timers sharing one prescaled count tick,
// with an all-enabled-channels-done summary.
module dly_timer_bank
    import dly_timer_pkg::*;
#(
    parameter int CH_NUM   = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 1
) (
    input  logic                    clk_in,
    input  logic                    iRst_n,
    input  logic [CH_NUM-1:0]       iClear,
    input  logic [CH_NUM-1:0]       iEn,
    input  logic [CH_NUM*CNT_W-1:0] iDlyTime,
    input  logic [CH_NUM*2-1:0]     iMode,
    output logic [CH_NUM-1:0]       oTimeout,
    output logic [CH_NUM-1:0]       oRise,
    output logic                    oAllDone
);

    logic tick;

    generate
        if (PRESCALE == 1) begin : g_no_pre
            assign tick = 1'b1;
        end else begin : g_pre
            localparam int PW = clog2(PRESCALE);
            localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] pre_reg;

            // Free-running; channel enables never restart it.
            always_ff @(posedge clk_in or negedge iRst_n) begin
                if (!iRst_n) begin
                    pre_reg <= '0;
                end else if (pre_reg == PRE_LAST) begin
                    pre_reg <= '0;
                end else begin
                    pre_reg <= pre_reg + 1'b1;
                end
            end

            assign tick = (pre_reg == PRE_LAST);
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            dly_timer_ch #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk_in   (clk_in),
                .iRst_n   (iRst_n),
                .tick     (tick),
                .clear_n  (iClear[gi]),
                .en       (iEn[gi]),
                .dly_time (iDlyTime[gi*CNT_W +: CNT_W]),
                .mode     (iMode[2*gi +: 2]),
                .timeout  (oTimeout[gi]),
                .rise     (oRise[gi])
            );
        end
    endgenerate

    assign oAllDone = (&(~iEn | oTimeout)) & (|iEn);

endmodule

// File: tb/tb_dly_timer_bank.sv
// Bench for dly_timer_bank: PRESCALE=1 and PRESCALE=10 instances share stimulus
// and are compared every cycle against a behavioural model, plus directed checks.
module tb_dly_timer_bank;

    localparam int CH = 4;
    localparam int W  = 16;

    logic          clk_in = 1'b0;
    logic          iRst_n = 1'b0;
    logic [CH-1:0] iClear;
    logic [CH-1:0] iEn;
    logic [CH*W-1:0] iDlyTime;
    logic [CH*2-1:0] iMode;
    logic [CH-1:0] to0, rise0, to1, rise1;
    logic          done0, done1;

    always #5 clk_in = ~clk_in;

    dly_timer_bank #(.CH_NUM(CH), .CNT_W(W), .PRESCALE(1)) u_dut (
        .clk_in(clk_in), .iRst_n(iRst_n), .iClear(iClear), .iEn(iEn),
        .iDlyTime(iDlyTime), .iMode(iMode),
        .oTimeout(to0), .oRise(rise0), .oAllDone(done0)
    );

    dly_timer_bank #(.CH_NUM(CH), .CNT_W(W), .PRESCALE(10)) u_dut_p (
        .clk_in(clk_in), .iRst_n(iRst_n), .iClear(iClear), .iEn(iEn),
        .iDlyTime(iDlyTime), .iMode(iMode),
        .oTimeout(to1), .oRise(rise1), .oAllDone(done1)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural reference: index 0 = PRESCALE 1, index 1 = PRESCALE 10.
    int m_cnt   [2][CH];
    bit m_to    [2][CH];
    bit m_toq   [2][CH];
    bit m_rise  [2][CH];
    bit m_spent [2][CH];
    int m_pre   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int prescale_of(input int d);
        return (d == 0) ? 1 : 10;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pre[d] = 0;
            for (int k = 0; k < CH; k++) begin
                m_cnt[d][k] = 0; m_to[d][k] = 0; m_toq[d][k] = 0;
                m_rise[d][k] = 0; m_spent[d][k] = 0;
            end
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit tk;
            tk = (m_pre[d] == prescale_of(d) - 1);
            m_pre[d] = (m_pre[d] + 1) % prescale_of(d);
            for (int k = 0; k < CH; k++) begin
                int dly;
                int md;
                dly = int'(iDlyTime[k*W +: W]);
                md  = int'(iMode[2*k +: 2]);
                m_rise[d][k] = m_to[d][k] && !m_toq[d][k];
                m_toq[d][k]  = m_to[d][k];
                if (!iClear[k] || !iEn[k]) begin
                    m_cnt[d][k] = 0; m_to[d][k] = 0; m_spent[d][k] = 0;
                end else if (m_spent[d][k] && md != 0) begin
                    m_to[d][k] = (md != 2);
                end else if (tk && m_cnt[d][k] >= dly) begin
                    m_to[d][k] = 1;
                    if (md == 0) m_cnt[d][k] = 0;
                    else m_spent[d][k] = 1;
                end else begin
                    m_to[d][k] = 0;
                    if (tk) m_cnt[d][k]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            logic [CH-1:0] e_to, e_rise;
            bit ok, any;
            ok = 1; any = 0;
            for (int k = 0; k < CH; k++) begin
                e_to[k]   = m_to[d][k];
                e_rise[k] = m_rise[d][k];
                if (iEn[k]) any = 1;
                if (iEn[k] && !m_to[d][k]) ok = 0;
            end
            chk(d == 0 ? "to_p1" : "to_p10", 32'(d == 0 ? to0 : to1), 32'(e_to));
            chk(d == 0 ? "rise_p1" : "rise_p10", 32'(d == 0 ? rise0 : rise1), 32'(e_rise));
            chk(d == 0 ? "done_p1" : "done_p10", 32'(d == 0 ? done0 : done1), 32'(ok && any));
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        if (iRst_n) model_step();
        #1;
        compare_all();
    endtask

    task automatic set_ch(input int k, input int dly, input logic [1:0] md);
        iDlyTime[k*W +: W] = 16'(dly);
        iMode[2*k +: 2]    = md;
    endtask

    initial begin
        int e;
        iClear = '1; iEn = '0; iDlyTime = '0; iMode = '0;
        model_reset();
        #12;
        chk("rst_to", 32'({to1, to0}), 32'd0);
        chk("rst_rise", 32'({rise1, rise0}), 32'd0);
        chk("rst_done", 32'({done1, done0}), 32'd0);
        #10 iRst_n = 1'b1;
        cycle();

        // Edge 0 is the edge just passed; enables are first sampled at edge 1.
        cycle();
        set_ch(0, 5, 2'b01); set_ch(1, 3, 2'b00); set_ch(2, 0, 2'b10);
        iEn = 4'b0111;
        for (e = 1; e <= 50; e++) begin
            cycle();
            chk("latch_to", 32'(to0[0]), 32'(e >= 6));
            chk("latch_rise", 32'(rise0[0]), 32'(e == 7));
            if (e <= 13) begin
                chk("per_to", 32'(to0[1]), 32'(e % 4 == 0));
                chk("per_rise", 32'(rise0[1]), 32'(e > 1 && (e - 1) % 4 == 0));
            end
            chk("oneshot_to", 32'(to0[2]), 32'(e == 1));
        end
        iEn[0] = 1'b0;
        cycle();
        chk("latch_dis", 32'(to0[0]), 32'd0);
        iClear[2] = 1'b0;
        cycle();
        iClear[2] = 1'b1;
        cycle();
        chk("oneshot_refire", 32'(to0[2]), 32'd1);
        cycle();
        chk("oneshot_drop", 32'(to0[2]), 32'd0);

        // Clear on the exact expiry edge wins.
        iEn = '0;
        cycle();
        set_ch(0, 5, 2'b01);
        iEn[0] = 1'b1;
        repeat (5) cycle();
        chk("pre_expiry", 32'(to0[0]), 32'd0);
        iClear[0] = 1'b0;
        cycle();
        chk("clr_wins", 32'(to0[0]), 32'd0);
        iClear[0] = 1'b1;

        // Live compare: lowering below cnt expires next tick; raising keeps latch.
        iEn = '0;
        cycle();
        set_ch(0, 100, 2'b01);
        iEn[0] = 1'b1;
        repeat (40) cycle();
        chk("dly_mid", 32'(to0[0]), 32'd0);
        set_ch(0, 10, 2'b01);
        cycle();
        chk("dly_lower", 32'(to0[0]), 32'd1);
        set_ch(0, 100, 2'b01);
        cycle();
        chk("dly_raise_hold", 32'(to0[0]), 32'd1);

        // All-done summary with two enabled LATCH channels.
        iEn = '0;
        #1;
        chk("done_none", 32'(done0), 32'd0);
        cycle();
        set_ch(0, 3, 2'b01); set_ch(1, 7, 2'b01);
        iEn = 4'b0011;
        for (e = 1; e <= 10; e++) begin
            cycle();
            chk("alldone", 32'(done0), 32'(e >= 8));
        end

        // PRESCALE=10, LATCH, delay 2: both extreme prescaler phases.
        iEn = '0;
        cycle();
        set_ch(3, 2, 2'b01);
        for (int ph = 0; ph < 2; ph++) begin
            int target;
            int guard;
            target = (ph == 0) ? 9 : 0;
            guard = 0;
            while (m_pre[1] != target && guard < 20) begin
                cycle();
                guard++;
            end
            iEn[3] = 1'b1;
            e = 0;
            while (e < 40) begin
                cycle();
                e++;
                if (to1[3]) break;
            end
            chk("pre_latency", 32'(e), 32'(ph == 0 ? 21 : 30));
            iEn[3] = 1'b0;
            cycle();
        end

        // Randomised traffic; modes only change while a channel is disabled.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, 15) == 0) iEn[k] = ~iEn[k];
                if (!iEn[k] && $urandom_range(0, 3) == 0)
                    iMode[2*k +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 31) == 0)
                    iDlyTime[k*W +: W] = 16'($urandom_range(0, 12));
                iClear[k] = ($urandom_range(0, 39) != 0);
            end
            cycle();
        end

        // Asynchronous reset mid-count.
        iClear = '1;
        for (int k = 0; k < CH; k++) set_ch(k, 20, 2'b01);
        iEn = '1;
        repeat (8) cycle();
        #2 iRst_n = 1'b0;
        #1;
        chk("arst_to", 32'({to1, to0}), 32'd0);
        chk("arst_rise", 32'({rise1, rise0}), 32'd0);
        chk("arst_done", 32'({done1, done0}), 32'd0);
        model_reset();
        #1 iRst_n = 1'b1;
        repeat (30) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
